keypad_scan: RTL and testbench

- Scans a 4x4 matrix keypad (Pmod KYPD style) and delivers debounced hex key codes to game control logic.
- Input-side counterpart of the multiplexed 7-segment driver: drives one active-low column at a time and reads the active-low rows.
- Emits a one-cycle press event plus a held level, so players can enter ship/shot coordinates that are then echoed on the display.

---
 rtl/keypad_scan.sv | 272 +++++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, synchronizes the
// active-low rows, classifies each 4-column frame and debounces presses and releases.
module keypad_scan #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] col,
   input  logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic             ONE_SHOT = (DEBOUNCE == 1);

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_DEB_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_DEB_RELEASE = 2'd3
   } state_t;

   // Bit position col*4+row of the frame vector maps to the printed key legend.
   function automatic logic [3:0] key_map(input logic [3:0] pos);
      logic [3:0] code;
      case (pos)
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h4;
         4'd2:    code = 4'h7;
         4'd3:    code = 4'h0;
         4'd4:    code = 4'h2;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h8;
         4'd7:    code = 4'hF;
         4'd8:    code = 4'h3;
         4'd9:    code = 4'h6;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hE;
         4'd12:   code = 4'hA;
         4'd13:   code = 4'hB;
         4'd14:   code = 4'hC;
         4'd15:   code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      logic [3:0] drv;
      case (idx)
         2'd0:    drv = 4'b1110;
         2'd1:    drv = 4'b1101;
         2'd2:    drv = 4'b1011;
         2'd3:    drv = 4'b0111;
         default: drv = 4'b1110;
      endcase
      return drv;
   endfunction

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   // Only meaningful when exactly one bit is set.
   function automatic logic [3:0] encode16(input logic [15:0] v);
      logic [3:0] code;
      code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) begin
            code = key_map(4'(i));
         end else begin
            code = code;
         end
      end
      return code;
   endfunction

   logic [3:0]       r_row_meta;
   logic [3:0]       r_row_sync;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_col_idx;
   logic [3:0]       r_col;
   logic [15:0]      r_frame;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_cand;
   logic [3:0]       r_code;
   logic             r_valid;
   logic             r_held;

   logic             w_div_end;
   logic             w_frame_end;
   logic [3:0]       w_pressed;
   logic [3:0]       w_shift;
   logic [15:0]      w_col_bits;
   logic [15:0]      w_frame_all;
   logic             w_single;
   logic [3:0]       w_code;
   logic             w_match_cand;
   logic             w_match_code;
   logic [CNT_W-1:0] w_cnt_inc;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       w_cand_nxt;
   logic [3:0]       w_code_nxt;
   logic             w_valid_nxt;
   logic             w_held_nxt;

   assign w_div_end    = (r_div == DIV_LAST);
   assign w_frame_end  = w_div_end && (r_col_idx == 2'd3);
   assign w_pressed    = ~r_row_sync;
   assign w_shift      = {r_col_idx, 2'b00};
   assign w_col_bits   = {12'h000, w_pressed} << w_shift;
   assign w_frame_all  = r_frame | w_col_bits;
   assign w_single     = (popcount16(w_frame_all) == 5'd1);
   assign w_code       = encode16(w_frame_all);
   assign w_match_cand = w_single && (w_code == r_cand);
   assign w_match_code = w_single && (w_code == r_code);
   assign w_cnt_inc    = r_cnt + CNT_ONE;

   assign col       = r_col;
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = r_held;

   // Two-flop synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_meta <= 4'b1111;
         r_row_sync <= 4'b1111;
      end else begin
         r_row_meta <= row;
         r_row_sync <= r_row_meta;
      end
   end

   // Column divider, column drive and per-frame accumulation of pressed positions.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div     <= {DIV_W{1'b0}};
         r_col_idx <= 2'd0;
         r_col     <= 4'b1110;
         r_frame   <= 16'h0000;
      end else if (w_div_end) begin
         r_div     <= {DIV_W{1'b0}};
         r_col_idx <= r_col_idx + 2'd1;
         r_col     <= col_drive(r_col_idx + 2'd1);
         if (r_col_idx == 2'd3) begin
            r_frame <= 16'h0000;
         end else begin
            r_frame <= w_frame_all;
         end
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Debounce state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= CNT_ZERO;
         r_cand  <= 4'h0;
         r_code  <= 4'h0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
         r_code  <= w_code_nxt;
         r_valid <= w_valid_nxt;
         r_held  <= w_held_nxt;
      end
   end

   // Next-state logic; decisions are taken only on the frame-end cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_code_nxt  = r_code;
      w_valid_nxt = 1'b0;
      w_held_nxt  = r_held;
      if (w_frame_end) begin
         case (r_state)
            ST_IDLE: begin
               if (w_single) begin
                  w_cand_nxt = w_code;
                  if (ONE_SHOT) begin
                     w_code_nxt  = w_code;
                     w_valid_nxt = 1'b1;
                     w_held_nxt  = 1'b1;
                     w_cnt_nxt   = CNT_ZERO;
                     w_state_nxt = ST_PRESSED;
                  end else begin
                     w_cnt_nxt   = CNT_ONE;
                     w_state_nxt = ST_DEB_PRESS;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_DEB_PRESS: begin
               if (w_match_cand) begin
                  if (w_cnt_inc >= CNT_DONE) begin
                     w_code_nxt  = r_cand;
                     w_valid_nxt = 1'b1;
                     w_held_nxt  = 1'b1;
                     w_cnt_nxt   = CNT_ZERO;
                     w_state_nxt = ST_PRESSED;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else if (w_single) begin
                  w_cand_nxt = w_code;
                  w_cnt_nxt  = CNT_ONE;
               end else begin
                  w_cnt_nxt   = CNT_ZERO;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               if (w_match_code) begin
                  w_state_nxt = ST_PRESSED;
               end else if (ONE_SHOT) begin
                  w_held_nxt  = 1'b0;
                  w_cnt_nxt   = CNT_ZERO;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt   = CNT_ONE;
                  w_state_nxt = ST_DEB_RELEASE;
               end
            end
            ST_DEB_RELEASE: begin
               if (w_match_code) begin
                  w_cnt_nxt   = CNT_ZERO;
                  w_state_nxt = ST_PRESSED;
               end else if (w_cnt_inc >= CNT_DONE) begin
                  w_held_nxt  = 1'b0;
                  w_cnt_nxt   = CNT_ZERO;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            default: begin
               w_held_nxt  = 1'b0;
               w_cnt_nxt   = CNT_ZERO;
               w_state_nxt = ST_IDLE;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=2): a key-matrix model drives the rows,
// expected press events are queued with their due cycle and checked when key_valid pulses.
module tb_keypad_scan;

   localparam int FRAME = 16;
   localparam int DEB   = 2;

   typedef struct {
      logic [3:0] code;
      int         t;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] keys;
   int          t_cyc;
   int          n_checks;
   int          n_errors;
   bit          mon_en;
   exp_t        exp_q[$];

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col),
      .row       (row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release; frame f ends on the posedge that makes t_cyc = 16*(f+1).
   always @(posedge clk) begin
      if (rst) t_cyc <= 0;
      else     t_cyc <= t_cyc + 1;
   end

   // Keypad matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (col[c] === 1'b0 && keys[c*4+r]) row[r] = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp_v, t_cyc);
      end
   endtask

   task automatic expect_key(input logic [3:0] c);
      exp_t e;
      e.code = c;
      e.t    = t_cyc + DEB * FRAME;
      exp_q.push_back(e);
   endtask

   task automatic run_frames(input int n);
      repeat (n * FRAME) @(negedge clk);
   endtask

   // Scoreboard: every key_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (mon_en && key_valid !== 1'b0) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_valid observed=%0h expected=none t=%0d", key_code, t_cyc);
         end
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("valid_code", {28'd0, key_code}, {28'd0, e.code});
            check("valid_time", t_cyc, e.t);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      keys     = 16'h0000;
      rst      = 1'b1;

      // Reset and first column step
      repeat (3) @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      check("rst_col",   col, 4'b1110);
      check("rst_valid", key_valid, 1'b0);
      check("rst_held",  key_held, 1'b0);
      check("rst_code",  key_code, 4'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("col_hold0", col, 4'b1110);
      @(negedge clk);
      check("col_step1", col, 4'b1101);
      while (t_cyc % FRAME != 0) @(negedge clk);

      // Single press of key 5, held four frames, then released
      keys = 16'h0000;
      keys[5] = 1'b1;
      expect_key(4'h5);
      run_frames(4);
      check("k5_held", key_held, 1'b1);
      check("k5_code", key_code, 4'h5);
      keys = 16'h0000;
      run_frames(1);
      check("k5_rel_pending", key_held, 1'b1);
      run_frames(1);
      check("k5_released", key_held, 1'b0);
      check("k5_code_kept", key_code, 4'h5);

      // Bouncing key 9, then stable
      for (int i = 0; i < 6; i++) begin
         keys = 16'h0000;
         keys[10] = (i % 2 == 0);
         run_frames(1);
      end
      check("bounce_no_held", key_held, 1'b0);
      keys = 16'h0000;
      keys[10] = 1'b1;
      expect_key(4'h9);
      run_frames(3);
      check("k9_code", key_code, 4'h9);
      check("k9_held", key_held, 1'b1);
      keys = 16'h0000;
      run_frames(2);
      check("k9_released", key_held, 1'b0);

      // Keys 1 and 2 together are ignored; key 1 alone is accepted
      keys = 16'h0000;
      keys[0] = 1'b1;
      keys[4] = 1'b1;
      run_frames(3);
      check("multi_no_held", key_held, 1'b0);
      check("multi_code_kept", key_code, 4'h9);
      keys[4] = 1'b0;
      expect_key(4'h1);
      run_frames(3);
      check("k1_code", key_code, 4'h1);
      check("k1_held", key_held, 1'b1);
      keys = 16'h0000;
      run_frames(2);
      check("k1_released", key_held, 1'b0);

      // Hold A, add D, then release A leaving D
      keys[12] = 1'b1;
      expect_key(4'hA);
      run_frames(3);
      check("kA_code", key_code, 4'hA);
      check("kA_held", key_held, 1'b1);
      keys[15] = 1'b1;
      run_frames(1);
      check("AD_pending", key_held, 1'b1);
      run_frames(1);
      check("AD_released", key_held, 1'b0);
      run_frames(1);
      check("AD_code_kept", key_code, 4'hA);
      keys[12] = 1'b0;
      expect_key(4'hD);
      run_frames(3);
      check("kD_code", key_code, 4'hD);
      check("kD_held", key_held, 1'b1);
      keys = 16'h0000;
      run_frames(2);
      check("kD_released", key_held, 1'b0);

      // Reset during debounce of key 0; key is re-debounced afterwards
      keys[3] = 1'b1;
      run_frames(1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_col",   col, 4'b1110);
      check("mid_rst_code",  key_code, 4'h0);
      check("mid_rst_held",  key_held, 1'b0);
      check("mid_rst_valid", key_valid, 1'b0);
      rst = 1'b0;
      expect_key(4'h0);
      run_frames(3);
      check("k0_held", key_held, 1'b1);
      check("k0_code", key_code, 4'h0);
      keys = 16'h0000;
      run_frames(2);
      check("k0_released", key_held, 1'b0);

      run_frames(1);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
